// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned DefaultNreq    = 4;
    localparam int unsigned DefaultTimeout = 1024;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first set bit of valid_i at or after (ptr_i+1) mod NREQ.
module rr_picker #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         valid_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic                    found_o,
    output logic [$clog2(NREQ)-1:0] idx_o
);

    localparam int unsigned W = $clog2(NREQ);

    logic [W-1:0] cand;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = W'((32'(ptr_i) + 32'(i) + 32'd1) % NREQ);
            if (valid_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART byte stream through a
// single output byte register, with a mid-packet stall timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ    = DefaultNreq,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [NREQ-1:0]         req_valid,
    input  byte_t [NREQ-1:0]        req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              tx_tdata,
    output logic                    tx_tvalid,
    input  logic                    tx_tready,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout
);

    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] StallMax = CW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] stall_q, stall_d;
    byte_t         tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          timeout_q, timeout_d;

    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic          lock, tx_free, sel_valid, sel_last, req_hs, expire;

    rr_picker #(
        .NREQ(NREQ)
    ) u_picker (
        .valid_i(req_valid),
        .ptr_i  (rr_ptr_q),
        .found_o(pick_found),
        .idx_o  (pick_idx)
    );

    always_comb begin
        lock      = (state_q == StLock);
        tx_free   = !tvalid_q || tx_tready;
        sel_valid = req_valid[grant_q];
        sel_last  = req_last[grant_q];
        req_hs    = lock && sel_valid && tx_free;
        // A handshake on the expiry cycle clears the counter, so it wins.
        expire    = lock && !req_hs && (stall_q == StallMax);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        stall_d   = stall_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_d = '0;
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = StLock;
                end
            end
            StLock: begin
                if (req_hs) begin
                    stall_d = '0;
                    if (sel_last) begin
                        state_d  = StIdle;
                        rr_ptr_d = grant_q;
                    end
                end else if (expire) begin
                    state_d   = StIdle;
                    rr_ptr_d  = grant_q;
                    stall_d   = '0;
                    timeout_d = 1'b1;
                end else if (!sel_valid) begin
                    stall_d = stall_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        if (req_hs) begin
            tdata_d  = req_data[grant_q];
            tvalid_d = 1'b1;
        end else if (tvalid_q && tx_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_ptr_q  <= GW'(NREQ - 1);
            stall_q   <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            stall_q   <= stall_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = lock && (grant_q == GW'(i)) && tx_free;
        end
    end

    assign tx_tdata  = tdata_q;
    assign tx_tvalid = tvalid_q;
    assign grant_id  = grant_q;
    assign busy      = lock;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, TIMEOUT=8).
module tb_uart_tx_arbiter;

    logic            clk = 1'b0;
    logic            nrst;
    logic [3:0]      req_valid, req_last, req_ready;
    logic [3:0][7:0] req_data;
    logic [7:0]      tx_tdata;
    logic            tx_tvalid, tx_tready;
    logic [1:0]      grant_id;
    logic            busy, timeout;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NREQ   (4),
        .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_tdata (tx_tdata),
        .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_tready = 1'b1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        clear_inputs();
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        clear_inputs();
        req_valid = 4'b1111;
        tick();
        tick();
        #1;
        checks++;
        if ({tx_tvalid, busy, timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {tx_tvalid, busy, timeout});
        end
        checks++;
        if (tx_tdata !== 8'h00 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d want 00/0", tx_tdata, grant_id);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        tick();
        nrst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_ready got %b busy %b want 0000 busy 0", req_ready, busy);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL first_grant got busy %b id %0d want 1 0", busy, grant_id);
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] bytes [3];
        bytes[0] = 8'h41;
        bytes[1] = 8'h42;
        bytes[2] = 8'h43;
        do_reset();
        req_valid   = 4'b0001;
        req_data[0] = bytes[0];
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got ready %b busy %b want 0000 0", req_ready, busy);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || tx_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_lock got busy %b id %0d ready %b tv %b want 1 0 0001 0",
                     busy, grant_id, req_ready, tx_tvalid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k < 2) begin
                req_data[0] = bytes[k+1];
                req_last[0] = (k == 1);
            end else begin
                req_valid = '0;
                req_last  = '0;
            end
            #1;
            checks++;
            if (tx_tvalid !== 1'b1 || tx_tdata !== bytes[k]) begin
                errors++;
                $display("FAIL single_byte%0d got %b/%h want 1/%h", k, tx_tvalid, tx_tdata, bytes[k]);
            end
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_done got busy %b id %0d want 0 0", busy, grant_id);
        end
        tick();
        #1;
        checks++;
        if (tx_tvalid !== 1'b0 || tx_tdata !== 8'h43 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_drain got %b/%h id %0d want 0/43 0", tx_tvalid, tx_tdata, grant_id);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd2;
        order[3] = 2'd3;
        order[4] = 2'd0;
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[i] = 8'h20 + 8'(i);
        for (int p = 0; p < 5; p++) begin
            tick();
            #1;
            checks++;
            if (busy !== 1'b1 || grant_id !== order[p] || req_ready !== (4'b0001 << order[p])) begin
                errors++;
                $display("FAIL rr_grant%0d got busy %b id %0d ready %b want 1 %0d",
                         p, busy, grant_id, req_ready, order[p]);
            end
            tick();
            #1;
            checks++;
            if (busy !== 1'b0 || tx_tvalid !== 1'b1 || tx_tdata !== 8'h20 + 8'(order[p])) begin
                errors++;
                $display("FAIL rr_byte%0d got busy %b %b/%h want 0 1/%h",
                         p, busy, tx_tvalid, tx_tdata, 8'h20 + 8'(order[p]));
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        req_valid   = 4'b0100;
        req_data[2] = 8'h10;
        tick();
        tick();
        tx_tready   = 1'b0;
        req_data[2] = 8'h11;
        req_last[2] = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (tx_tdata !== 8'h10 || tx_tvalid !== 1'b1 || req_ready !== 4'b0000 ||
                timeout !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stable got %0d bad cycles want 0", bad);
        end
        tx_tready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL bp_resume got ready %b id %0d want 0100 2", req_ready, grant_id);
        end
        tick();
        req_valid = '0;
        req_last  = '0;
        #1;
        checks++;
        if (tx_tdata !== 8'h11 || tx_tvalid !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL bp_last got %h/%b busy %b to %b want 11/1 0 0",
                     tx_tdata, tx_tvalid, busy, timeout);
        end
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        req_valid   = 4'b0010;
        req_data[1] = 8'h55;
        tick();
        tick();
        req_valid   = 4'b0101;
        req_data[2] = 8'h66;
        req_last[2] = 1'b1;
        #1;
        checks++;
        if (tx_tdata !== 8'h55 || tx_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL to_byte got %h/%b want 55/1", tx_tdata, tx_tvalid);
        end
        early = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) #1;
            if (timeout !== 1'b0 || busy !== 1'b1) early++;
            tick();
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL to_early got %0d bad cycles want 0", early);
        end
        #1;
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL to_pulse got to %b busy %b id %0d want 1 0 1", timeout, busy, grant_id);
        end
        checks++;
        if (tx_tdata !== 8'h55 || tx_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL to_hold got %h/%b want 55/0", tx_tdata, tx_tvalid);
        end
        tick();
        req_valid = '0;
        req_last  = '0;
        #1;
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL to_next got to %b busy %b id %0d want 0 1 2", timeout, busy, grant_id);
        end
    endtask

    task automatic test_last_on_expiry();
        int seen;
        do_reset();
        req_valid   = 4'b0010;
        req_data[1] = 8'h77;
        tick();
        tick();
        req_valid = '0;
        for (int c = 0; c < 7; c++) tick();
        req_valid   = 4'b0010;
        req_data[1] = 8'h78;
        req_last[1] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL exp_ready got %b busy %b want 0010 1", req_ready, busy);
        end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 0) begin
                req_valid = '0;
                req_last  = '0;
            end
            #1;
            if (timeout !== 1'b0) seen++;
            if (c == 0) begin
                checks++;
                if (busy !== 1'b0 || tx_tdata !== 8'h78 || tx_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL exp_last got busy %b %h/%b want 0 78/1", busy, tx_tdata, tx_tvalid);
                end
            end
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL exp_nopulse got %0d pulse cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req_valid   = 4'b0100;
        req_data[2] = 8'h99;
        tx_tready   = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h99 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL mid_setup got %b/%h id %0d want 1/99 2", tx_tvalid, tx_tdata, grant_id);
        end
        nrst      = 1'b0;
        req_valid = 4'b0101;
        #1;
        checks++;
        if (tx_tvalid !== 1'b0 || tx_tdata !== 8'h00 || busy !== 1'b0 ||
            grant_id !== 2'd0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_async got %b/%h busy %b id %0d ready %b want 0/00 0 0 0000",
                     tx_tvalid, tx_tdata, busy, grant_id, req_ready);
        end
        tick();
        nrst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_release got ready %b busy %b want 0000 0", req_ready, busy);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_regrant got busy %b id %0d want 1 0", busy, grant_id);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_last_on_expiry();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
